// File: rtl/text_scan_controller_if.sv
// rtl/text_scan_controller_if.sv - text-mode scan bus: pixel enable and blanking in, RAM/generator/VGA timing out
interface text_scan_controller_if #(
   parameter int ADDR_W = 12
);
   logic              pix_ce;
   logic              blank_req;
   logic [ADDR_W-1:0] char_addr;
   logic              char_rd;
   logic              gen_en;
   logic [2:0]        dot_count;
   logic [3:0]        scan_count;
   logic              hsync;
   logic              vsync;
   logic              video_on;
   logic              frame_start;

   modport master (
      input  pix_ce, blank_req,
      output char_addr, char_rd, gen_en, dot_count, scan_count,
             hsync, vsync, video_on, frame_start
   );

   modport slave (
      output pix_ce, blank_req,
      input  char_addr, char_rd, gen_en, dot_count, scan_count,
             hsync, vsync, video_on, frame_start
   );
endinterface

// File: rtl/text_scan_controller.sv
// rtl/text_scan_controller.sv - raster counters, text RAM addressing and 3-stage aligned sync/video pipeline
module text_scan_controller #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int COLS     = 80,
   parameter int ADDR_W   = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   text_scan_controller_if.master bus
);
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW       = $clog2(H_TOTAL + 1);
   localparam int VW       = $clog2(V_TOTAL + 1);
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   logic [HW-1:0]     h_cnt;
   logic [VW-1:0]     v_cnt;

   logic              active_c;
   logic              hsync_c;
   logic              vsync_c;
   logic              frame_c;
   logic [ADDR_W-1:0] addr_c;

   // stage 0: address/strobe toward the text RAM
   logic              act0;
   logic [ADDR_W-1:0] addr0;
   logic              rd0;
   logic              fs0;
   logic [2:0]        dot0;
   logic [3:0]        scan0;
   logic              hs0;
   logic              vs0;

   // stage 1: RAM data valid, character_generator indexed
   logic              act1;
   logic [2:0]        dot1;
   logic [3:0]        scan1;
   logic              hs1;
   logic              vs1;

   // stage 2: aligned with the generator's registered pixel
   logic              hs2;
   logic              vs2;
   logic              vid2;

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (bus.pix_ce) begin
         if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      active_c = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
      addr_c   = '0;
      if (active_c)
         addr_c = ADDR_W'(v_cnt >> 4) * ADDR_W'(COLS) + ADDR_W'(h_cnt >> 3);
      hsync_c  = !((h_cnt >= HW'(HS_START)) && (h_cnt < HW'(HS_END)));
      vsync_c  = !((v_cnt >= VW'(VS_START)) && (v_cnt < VW'(VS_END)));
      frame_c  = (h_cnt == '0) && (v_cnt == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         act0  <= 1'b0;
         addr0 <= '0;
         rd0   <= 1'b0;
         fs0   <= 1'b0;
         dot0  <= '0;
         scan0 <= '0;
         hs0   <= 1'b1;
         vs0   <= 1'b1;
         act1  <= 1'b0;
         dot1  <= '0;
         scan1 <= '0;
         hs1   <= 1'b1;
         vs1   <= 1'b1;
         hs2   <= 1'b1;
         vs2   <= 1'b1;
         vid2  <= 1'b0;
      end else if (bus.pix_ce) begin
         act0  <= active_c;
         addr0 <= addr_c;
         rd0   <= active_c && (h_cnt[2:0] == 3'd0);
         fs0   <= frame_c;
         dot0  <= h_cnt[2:0];
         scan0 <= v_cnt[3:0];
         hs0   <= hsync_c;
         vs0   <= vsync_c;

         act1  <= act0;
         dot1  <= dot0;
         scan1 <= scan0;
         hs1   <= hs0;
         vs1   <= vs0;

         // blanking is applied here so it never disturbs sync timing
         hs2   <= hs1;
         vs2   <= vs1;
         vid2  <= act1 && !bus.blank_req;
      end
   end

   assign bus.char_addr   = addr0;
   assign bus.char_rd     = rd0;
   assign bus.frame_start = fs0;
   assign bus.gen_en      = act1;
   assign bus.dot_count   = dot1;
   assign bus.scan_count  = scan1;
   assign bus.hsync       = hs2;
   assign bus.vsync       = vs2;
   assign bus.video_on    = vid2;
endmodule

// File: tb/tb_text_scan_controller.sv
// tb/tb_text_scan_controller.sv - pixel-index reference model and directed timing checks for text_scan_controller
module tb_text_scan_controller;
   typedef struct packed {
      int ha, hf, hsw, hb, va, vf, vsw, vb, cols;
   } geom_t;

   typedef struct packed {
      logic [11:0] addr;
      logic        rd;
      logic        fs;
      logic        gen;
      logic [2:0]  dot;
      logic [3:0]  scan;
      logic        hs;
      logic        vs;
      logic        vid;
   } outs_t;

   localparam geom_t GD = '{640, 16, 96, 48, 480, 10, 2, 33, 80};
   localparam geom_t GS = '{64, 8, 16, 8, 48, 2, 2, 3, 8};

   logic clk       = 1'b0;
   logic rst       = 1'b1;
   logic pix_ce    = 1'b1;
   logic blank_req = 1'b0;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;
   int t = 0;
   bit blank_last = 1'b0;
   int win = 800;

   int cyc, fs_first, fs_first_s, fs_cnt_d, fs_cnt_s, hs_fall0, hs_fall1;
   int hs_low_w, vid_w, gen_w, gen_fall, vs_low_s, max_addr_s;
   int rd_cnt0, rd_first0, rd_last0, rd_cnt16, rd_first16, rd_last16;
   logic hs_prev, gen_prev;

   always #5 clk = ~clk;

   text_scan_controller_if #(.ADDR_W(12)) bus_d ();
   text_scan_controller_if #(.ADDR_W(12)) bus_s ();

   assign bus_d.pix_ce    = pix_ce;
   assign bus_d.blank_req = blank_req;
   assign bus_s.pix_ce    = pix_ce;
   assign bus_s.blank_req = blank_req;

   text_scan_controller dut_d (
      .clk (clk),
      .rst (rst),
      .bus (bus_d)
   );

   text_scan_controller #(
      .H_ACTIVE(64), .H_FP(8), .H_SYNC(16), .H_BP(8),
      .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .COLS(8), .ADDR_W(12)
   ) dut_s (
      .clk (clk),
      .rst (rst),
      .bus (bus_s)
   );

   function automatic void hv(input geom_t g, input int p, output int h, output int v);
      int htot, vtot;
      htot = g.ha + g.hf + g.hsw + g.hb;
      vtot = g.va + g.vf + g.vsw + g.vb;
      h = p % htot;
      v = (p / htot) % vtot;
   endfunction

   // tt = pix_ce edges since reset; stage k shows raster position tt-1-k
   function automatic outs_t model_outs(input geom_t g, input int tt, input bit blank);
      outs_t o;
      int h, v;
      o = '0;
      o.hs = 1'b1;
      o.vs = 1'b1;
      if (tt >= 1) begin
         hv(g, tt - 1, h, v);
         if (h < g.ha && v < g.va) begin
            o.addr = 12'((v / 16) * g.cols + h / 8);
            o.rd   = (h % 8 == 0);
         end
         o.fs = (h == 0 && v == 0);
      end
      if (tt >= 2) begin
         hv(g, tt - 2, h, v);
         o.gen  = (h < g.ha && v < g.va);
         o.dot  = 3'(h % 8);
         o.scan = 4'(v % 16);
      end
      if (tt >= 3) begin
         hv(g, tt - 3, h, v);
         o.hs  = !(h >= g.ha + g.hf && h < g.ha + g.hf + g.hsw);
         o.vs  = !(v >= g.va + g.vf && v < g.va + g.vf + g.vsw);
         o.vid = (h < g.ha && v < g.va) && !blank;
      end
      return o;
   endfunction

   task automatic cmp(input string name, input outs_t got, input outs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0d got addr=%0d rd=%b fs=%b gen=%b dot=%0d scan=%0d hs=%b vs=%b vid=%b want addr=%0d rd=%b fs=%b gen=%b dot=%0d scan=%0d hs=%b vs=%b vid=%b",
                  name, t, got.addr, got.rd, got.fs, got.gen, got.dot, got.scan, got.hs, got.vs, got.vid,
                  exp.addr, exp.rd, exp.fs, exp.gen, exp.dot, exp.scan, exp.hs, exp.vs, exp.vid);
      end
   endtask

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, got, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      if (rst) begin
         t = 0;
         blank_last = 1'b0;
      end else if (pix_ce) begin
         t++;
         blank_last = blank_req;
      end
   end

   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         cmp("model_default", {bus_d.char_addr, bus_d.char_rd, bus_d.frame_start, bus_d.gen_en,
                               bus_d.dot_count, bus_d.scan_count, bus_d.hsync, bus_d.vsync, bus_d.video_on},
             model_outs(GD, t, blank_last));
         cmp("model_small", {bus_s.char_addr, bus_s.char_rd, bus_s.frame_start, bus_s.gen_en,
                             bus_s.dot_count, bus_s.scan_count, bus_s.hsync, bus_s.vsync, bus_s.video_on},
             model_outs(GS, t, blank_last));
      end
   end

   initial begin : monitor
      int rel;
      forever begin
         @(negedge clk);
         if (rst) begin
            cyc = 0; fs_first = -1; fs_first_s = -1; fs_cnt_d = 0; fs_cnt_s = 0;
            hs_fall0 = -1; hs_fall1 = -1; hs_low_w = 0; vid_w = 0; gen_w = 0; gen_fall = -1;
            vs_low_s = 0; max_addr_s = -1;
            rd_cnt0 = 0; rd_first0 = -1; rd_last0 = -1; rd_cnt16 = 0; rd_first16 = -1; rd_last16 = -1;
            hs_prev = 1'b1; gen_prev = 1'b0;
         end else begin
            if (bus_d.frame_start) begin
               fs_cnt_d++;
               if (fs_first < 0) fs_first = cyc;
            end
            if (bus_s.frame_start) begin
               fs_cnt_s++;
               if (fs_first_s < 0) fs_first_s = cyc;
            end
            if (fs_first >= 0) begin
               rel = cyc - fs_first;
               if (rel < win) begin
                  if (!bus_d.hsync) hs_low_w++;
                  if (bus_d.video_on) vid_w++;
                  if (bus_d.gen_en) gen_w++;
                  if (bus_d.char_rd) begin
                     rd_cnt0++;
                     if (rd_first0 < 0) rd_first0 = int'(bus_d.char_addr);
                     rd_last0 = int'(bus_d.char_addr);
                  end
               end
               if (rel >= 16 * 800 && rel < 17 * 800 && bus_d.char_rd) begin
                  rd_cnt16++;
                  if (rd_first16 < 0) rd_first16 = int'(bus_d.char_addr);
                  rd_last16 = int'(bus_d.char_addr);
               end
               if (hs_prev && !bus_d.hsync) begin
                  if (hs_fall0 < 0) hs_fall0 = rel;
                  else if (hs_fall1 < 0) hs_fall1 = rel;
               end
               if (gen_prev && !bus_d.gen_en && gen_fall < 0) gen_fall = rel;
            end
            if (fs_first_s >= 0 && cyc - fs_first_s < 5280 && !bus_s.vsync) vs_low_s++;
            if (bus_s.char_rd && int'(bus_s.char_addr) > max_addr_s) max_addr_s = int'(bus_s.char_addr);
            hs_prev  = bus_d.hsync;
            gen_prev = bus_d.gen_en;
            cyc++;
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      cmp_en = 1'b1;
      check("reset_vec_default", int'({bus_d.char_addr, bus_d.char_rd, bus_d.gen_en, bus_d.dot_count, bus_d.scan_count,
                                       bus_d.video_on, bus_d.frame_start, bus_d.hsync, bus_d.vsync}), 3);

      // continuous pix_ce, 17 lines of the default raster
      @(posedge clk); #1 rst = 1'b0;
      repeat (13700) @(posedge clk);
      check("fs_count_default", fs_cnt_d, 1);
      check("fs_count_small", fs_cnt_s, 3);
      check("hsync_first_low", hs_fall0, 658);
      check("hsync_second_low", hs_fall1, 1458);
      check("hsync_low_len", hs_low_w, 96);
      check("video_on_len", vid_w, 640);
      check("gen_en_len", gen_w, 640);
      check("gen_en_fall", gen_fall, 641);
      check("line0_rd_count", rd_cnt0, 80);
      check("line0_first_addr", rd_first0, 0);
      check("line0_last_addr", rd_last0, 79);
      check("line16_rd_count", rd_cnt16, 80);
      check("line16_first_addr", rd_first16, 80);
      check("line16_last_addr", rd_last16, 159);
      check("small_vsync_low", vs_low_s, 192);
      check("small_last_addr", max_addr_s, 23);

      // mid-frame reset with pix_ce held high
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midframe_reset_default", int'({bus_d.char_addr, bus_d.char_rd, bus_d.gen_en, bus_d.dot_count, bus_d.scan_count,
                                            bus_d.video_on, bus_d.frame_start, bus_d.hsync, bus_d.vsync}), 3);
      check("midframe_reset_small", int'({bus_s.char_addr, bus_s.char_rd, bus_s.gen_en, bus_s.dot_count, bus_s.scan_count,
                                          bus_s.video_on, bus_s.frame_start, bus_s.hsync, bus_s.vsync}), 3);

      // release with pix_ce low, then alternate pix_ce
      @(posedge clk); #1 rst = 1'b0; pix_ce = 1'b0; win = 1600;
      repeat (3) @(posedge clk);
      #1 pix_ce = 1'b1;
      @(posedge clk); #1 pix_ce = 1'b0;
      @(negedge clk);
      check("first_ce_frame_start", int'(bus_d.frame_start), 1);
      check("first_ce_char_rd", int'(bus_d.char_rd), 1);
      check("first_ce_char_addr", int'(bus_d.char_addr), 0);
      for (int i = 2; i < 3100; i++) begin
         @(posedge clk); #1 pix_ce = (i % 2 == 0);
      end
      check("half_rate_hsync_first", hs_fall0, 1316);
      check("half_rate_line_len", hs_fall1 - hs_fall0, 1600);
      check("half_rate_hsync_len", hs_low_w, 192);
      check("half_rate_video_len", vid_w, 1280);
      check("half_rate_gen_fall", gen_fall, 1282);

      // blanking forced: sync untouched, video_on suppressed
      @(posedge clk); #1 rst = 1'b1; pix_ce = 1'b1; blank_req = 1'b1; win = 800;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (1700) @(posedge clk);
      check("blank_video_len", vid_w, 0);
      check("blank_hsync_first", hs_fall0, 658);
      check("blank_hsync_len", hs_low_w, 96);
      check("blank_gen_len", gen_w, 640);

      // irregular pix_ce and blanking, checked by the model only
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk);
         #1 pix_ce = 1'($urandom_range(0, 1));
         blank_req = ($urandom_range(0, 3) == 0);
      end

      @(negedge clk);
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
